vga_timing_gen: RTL and testbench

//   Free-running VGA display timing generator for the Nexys4 top level. Divides sysclk

---
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA display timing generator.
// A prescaler divides clk down to the pixel rate. Horizontal and vertical
// counters walk the raster, and every output is registered so that all
// outputs stay mutually aligned and change only on the pix_tick cycle.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0] PRE_LAST = 5'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The prescaler resets to 0 so the first clk after reset is a tick.
  // hnext/vnext hold the position that will be presented on the next tick,
  // which lets reset land on (0,0) and present it immediately on release.
  logic [4:0] pre_q, pre_d;
  logic [9:0] hnext_q, hnext_d;
  logic [9:0] vnext_q, vnext_d;
  logic       tick_q, tick_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       fs_q, fs_d;
  logic       tick_now;

  // Next-state logic: advance prescaler and raster, decode outputs on a tick.
  always_comb begin
    tick_now = (pre_q == 5'd0);
    pre_d    = (pre_q == PRE_LAST) ? 5'd0 : pre_q + 5'd1;
    hnext_d  = hnext_q;
    vnext_d  = vnext_q;
    tick_d   = tick_now;
    fs_d     = 1'b0;
    hs_d     = hs_q;
    vs_d     = vs_q;
    von_d    = von_q;
    col_d    = col_q;
    row_d    = row_q;
    if (tick_now) begin
      col_d = hnext_q;
      row_d = vnext_q;
      fs_d  = (hnext_q == 10'd0) && (vnext_q == 10'd0);
      hs_d  = ((hnext_q >= HS_FIRST) && (hnext_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = ((vnext_q >= VS_FIRST) && (vnext_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      von_d = (hnext_q < H_VIS) && (vnext_q < V_VIS);
      if (hnext_q == H_LAST) begin
        hnext_d = 10'd0;
        vnext_d = (vnext_q == V_LAST) ? 10'd0 : vnext_q + 10'd1;
      end else begin
        hnext_d = hnext_q + 10'd1;
      end
    end
  end

  // State and output registers; reset parks everything at the idle levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= 5'd0;
      hnext_q <= 10'd0;
      vnext_q <= 10'd0;
      tick_q  <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      von_q   <= 1'b0;
      col_q   <= 10'd0;
      row_q   <= 10'd0;
    end else begin
      pre_q   <= pre_d;
      hnext_q <= hnext_d;
      vnext_q <= vnext_d;
      tick_q  <= tick_d;
      fs_q    <= fs_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      von_q   <= von_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign pix_tick     = tick_q;
  assign frame_start  = fs_q;
  assign horiz_sync   = hs_q;
  assign vert_sync    = vs_q;
  assign video_on     = von_q;
  assign pixel_column = col_q;
  assign pixel_row    = row_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default VGA timing, a small
// raster with active-high syncs, and CLK_DIV=1) share one reset and are checked
// every clk against a reference model that derives the expected outputs
// from the number of clks elapsed since reset was released.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = -1;            // clks since reset release; -1 while in reset
  int hs_low_def = 0;
  int vs_low_sml = 0;
  int last_fs_sml = -1;

  // Packed as {tick, hsync, vsync, video_on, col[9:0], row[9:0], frame_start}
  logic       d_tick, d_hs, d_vs, d_von, d_fs;
  logic [9:0] d_col, d_row;
  logic       s_tick, s_hs, s_vs, s_von, s_fs;
  logic [9:0] s_col, s_row;
  logic       f_tick, f_hs, f_vs, f_von, f_fs;
  logic [9:0] f_col, f_row;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst), .pix_tick(d_tick), .horiz_sync(d_hs), .vert_sync(d_vs),
    .video_on(d_von), .pixel_column(d_col), .pixel_row(d_row), .frame_start(d_fs));

  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)) u_sml (
    .clk(clk), .reset(rst), .pix_tick(s_tick), .horiz_sync(s_hs), .vert_sync(s_vs),
    .video_on(s_von), .pixel_column(s_col), .pixel_row(s_row), .frame_start(s_fs));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) u_fst (
    .clk(clk), .reset(rst), .pix_tick(f_tick), .horiz_sync(f_hs), .vert_sync(f_vs),
    .video_on(f_von), .pixel_column(f_col), .pixel_row(f_row), .frame_start(f_fs));

  // Reference: pixel index = clks / div; the raster position follows by division.
  function automatic logic [24:0] model(input int cnt, input int div,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb, input bit pol);
    int ht, vt, p, col, row;
    logic tick, hsy, vsy, von, fs;
    logic [9:0] c10, r10;
    if (cnt < 0) return {1'b0, ~pol, ~pol, 1'b0, 10'd0, 10'd0, 1'b0};
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    p    = cnt / div;
    tick = (cnt % div) == 0;
    col  = p % ht;
    row  = (p / ht) % vt;
    hsy  = (col >= ha + hf && col < ha + hf + hs) ? pol : ~pol;
    vsy  = (row >= va + vf && row < va + vf + vs) ? pol : ~pol;
    von  = (col < ha) && (row < va);
    fs   = tick && col == 0 && row == 0;
    c10  = 10'(col);
    r10  = 10'(row);
    return {tick, hsy, vsy, von, c10, r10, fs};
  endfunction

  task automatic check_vec(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s n=%0d: observed tick/hs/vs/von=%b col=%0d row=%0d fs=%b, expected tick/hs/vs/von=%b col=%0d row=%0d fs=%b",
             tag, n, obs[24:21], obs[20:11], obs[10:1], obs[0],
             exp[24:21], exp[20:11], exp[10:1], exp[0]);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk with reset driven to r; compares all three instances afterwards.
  task automatic cyc(input logic r);
    rst = r;
    @(posedge clk);
    n = r ? -1 : n + 1;
    @(negedge clk);
    check_vec("def", {d_tick, d_hs, d_vs, d_von, d_col, d_row, d_fs},
              model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    check_vec("sml", {s_tick, s_hs, s_vs, s_von, s_col, s_row, s_fs},
              model(n, 3, 20, 3, 4, 5, 6, 2, 2, 3, 1'b1));
    check_vec("fst", {f_tick, f_hs, f_vs, f_von, f_col, f_row, f_fs},
              model(n, 1, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0));
    if (n < 0) last_fs_sml = -1;
    if (n >= 0 && n < 3200 && d_hs == 1'b0) hs_low_def++;
    if (n >= 0 && n < 1248 && s_vs == 1'b1) vs_low_sml++;
    if (s_fs) begin
      if (last_fs_sml >= 0) check_int("sml_frame_period", n - last_fs_sml, 1248);
      last_fs_sml = n;
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) cyc(1'b1);
    check_int("rst_col", int'(d_col), 0);
    check_int("rst_hsync", int'(d_hs), 1);

    // Release: first clk presents (0,0) with frame_start.
    cyc(1'b0);
    check_vec("release_def", {d_tick, d_hs, d_vs, d_von, d_col, d_row, d_fs},
              {4'b1111, 10'd0, 10'd0, 1'b1});
    check_vec("release_fst", {f_tick, f_hs, f_vs, f_von, f_col, f_row, f_fs},
              {4'b1111, 10'd0, 10'd0, 1'b1});

    // Long run: three default lines, several small and fast frames.
    repeat (9999) cyc(1'b0);
    check_int("def_hsync_low_clks_line0", hs_low_def, 384);
    check_int("sml_vsync_active_clks_frame0", vs_low_sml, 192);

    // Reset mid-frame of the small raster, at column 15 row 4, held for 3 clks.
    for (int k = 0; k < 2000; k++) begin
      if (s_col == 10'd15 && s_row == 10'd4) break;
      cyc(1'b0);
    end
    check_int("sml_reached_15_4", int'({s_col, s_row}), int'({10'd15, 10'd4}));
    repeat (3) cyc(1'b1);
    repeat (1300) cyc(1'b0);

    // Randomized run lengths and reset pulses.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(1500, 20)) cyc(1'b0);
      repeat ($urandom_range(3, 1)) cyc(1'b1);
    end
    repeat (40) cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
